// File: rtl/vga_pkg.sv
// vga_pkg: shared frame geometry, address width and scan-out FSM states for the drawing blocks
package vga_pkg;
  localparam int WIDTH = 160;
  localparam int HEIGHT = 120;
  localparam int AW = 15;
  typedef enum logic [1:0] {IDLE, FETCH, SHOW, DONE} scan_state_t;
endpackage

// File: rtl/fb_scanout_if.sv
// fb_scanout_if: plot bus, scan control, pixel stream and counters; master drives plots/start/ready, slave is the frame buffer
interface fb_scanout_if;
  import vga_pkg::*;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic vga_plot;
  logic start;
  logic done;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic out_valid;
  logic out_ready;
  logic [AW-1:0] plot_count;
  logic [7:0] oob_count;
  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, start, out_ready,
    input done, out_x, out_y, out_colour, out_valid, plot_count, oob_count
  );
  modport slave (
    input vga_x, vga_y, vga_colour, vga_plot, start, out_ready,
    output done, out_x, out_y, out_colour, out_valid, plot_count, oob_count
  );
endinterface

// File: rtl/fb_ram.sv
// fb_ram: simple dual-port frame store; ports: clk, write (we/wa/wd), synchronous read (re/ra -> rd next cycle, old data on collision)
module fb_ram import vga_pkg::*; #(
  parameter int DEPTH = WIDTH * HEIGHT,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [DEPTH];
  // Non-blocking read of mem sees the pre-write contents on a same-address collision
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: frame buffer with plot port and handshaked raster scan-out; ports: clk, rst_n (sync, active-low), bus (fb_scanout_if.slave)
module fb_scanout import vga_pkg::*; #(
  parameter int WIDTH = vga_pkg::WIDTH,
  parameter int HEIGHT = vga_pkg::HEIGHT
) (
  input logic clk,
  input logic rst_n,
  fb_scanout_if.slave bus
);
  localparam logic [7:0] XL = 8'(WIDTH - 1);
  localparam logic [6:0] YL = 7'(HEIGHT - 1);
  scan_state_t state, state_n;
  logic [7:0] cx;
  logic [6:0] cy;
  logic [2:0] rd_data;
  logic [AW-1:0] wa, ra, plot_count;
  logic [7:0] oob_count;
  logic last, in_range, we;
  assign last = cx == XL && cy == YL;
  assign in_range = bus.vga_x <= XL && bus.vga_y <= YL;
  assign we = rst_n && bus.vga_plot && in_range;
  assign wa = AW'(bus.vga_y) * AW'(WIDTH) + AW'(bus.vga_x);
  assign ra = AW'(cy) * AW'(WIDTH) + AW'(cx);
  fb_ram #(.DEPTH(WIDTH * HEIGHT), .DW(3)) u_ram (
    .clk(clk),
    .we(we),
    .wa(wa),
    .wd(bus.vga_colour),
    .re(state == FETCH),
    .ra(ra),
    .rd(rd_data)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = bus.start ? FETCH : IDLE;
      FETCH: state_n = SHOW;
      SHOW:  state_n = bus.out_ready ? (last ? DONE : FETCH) : SHOW;
      DONE:  state_n = bus.start ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cx <= '0;
      cy <= '0;
    end else if (state == IDLE && bus.start) begin
      cx <= '0;
      cy <= '0;
    end else if (state == SHOW && bus.out_ready && !last) begin
      cx <= cx == XL ? '0 : cx + 8'd1;
      cy <= cx == XL ? cy + 7'd1 : cy;
    end
  end
  // Increment is the inverted all-ones flag, so a full counter adds zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      plot_count <= '0;
      oob_count <= '0;
    end else if (bus.vga_plot) begin
      if (in_range) plot_count <= plot_count + AW'(~&plot_count);
      else oob_count <= oob_count + 8'(~&oob_count);
    end
  end
  // Read data only reloads in FETCH, so it holds steady across a stalled SHOW
  assign bus.out_valid = state == SHOW;
  assign bus.done = state == DONE;
  assign bus.out_x = cx;
  assign bus.out_y = cy;
  assign bus.out_colour = state == SHOW ? rd_data : '0;
  assign bus.plot_count = plot_count;
  assign bus.oob_count = oob_count;
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: randomized self-checking bench for fb_scanout against an array-based frame model
module tb_fb_scanout;
  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  fb_scanout_if bus();
  fb_scanout dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int n_cmp = 0;
  int n_fail = 0;
  logic [2:0] model [N];
  int m_pc = 0;
  int m_oc = 0;

  task automatic plot(input int x, input int y, input int c);
    bus.vga_x = 8'(x);
    bus.vga_y = 7'(y);
    bus.vga_colour = 3'(c);
    bus.vga_plot = 1;
    if (x < W && y < H) begin
      model[y * W + x] = 3'(c);
      m_pc = m_pc < 32767 ? m_pc + 1 : m_pc;
    end else m_oc = m_oc < 255 ? m_oc + 1 : m_oc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.start = 0;
    bus.out_ready = 0;
    bus.vga_plot = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    m_pc = 0;
    m_oc = 0;
  endtask

  task automatic start_scan(input bit keep);
    bus.start = 1;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_fetch: out_valid=%b want 0", bus.out_valid); end
    if (!keep) bus.start = 0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_show: out_valid=%b want 1", bus.out_valid); end
  endtask

  // Consumes pixels first..first+npix-1; with rnd, stalls randomly and plots ahead of the cursor
  task automatic run_scan(input int first, input int npix, input bit rnd);
    for (int k = first; k < first + npix; k++) begin
      int t = 0;
      int ex = k % W;
      int ey = k / W;
      logic [2:0] ec = model[k];
      while (!bus.out_valid && t < 4) begin @(negedge clk); t++; end
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_x !== 8'(ex) || bus.out_y !== 7'(ey) || bus.out_colour !== ec) begin
        n_fail++;
        $display("FAIL pixel %0d: got v=%b (%0d,%0d) c=%0d, want v=1 (%0d,%0d) c=%0d",
                 k, bus.out_valid, bus.out_x, bus.out_y, bus.out_colour, ex, ey, ec);
        return;
      end
      if (!rnd && k > first) begin
        n_cmp++;
        if (t != 1) begin n_fail++; $display("FAIL gap pixel %0d: %0d cycles, want 1", k, t); end
      end
      if (rnd) begin
        int a = k + 2 + int'($urandom_range(0, 200));
        bus.out_ready = 0;
        bus.start = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) plot(160 + int'($urandom_range(0, 95)), int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
        else if (a < N) plot(a % W, a / W, int'($urandom_range(0, 7)));
        else @(negedge clk);
        bus.vga_plot = 0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_x !== 8'(ex) || bus.out_y !== 7'(ey) || bus.out_colour !== ec) begin
          n_fail++;
          $display("FAIL stall pixel %0d: got v=%b (%0d,%0d) c=%0d, want v=1 (%0d,%0d) c=%0d",
                   k, bus.out_valid, bus.out_x, bus.out_y, bus.out_colour, ex, ey, ec);
        end
      end
      bus.out_ready = 1;
      @(negedge clk);
      if (rnd) begin bus.out_ready = 0; bus.start = 0; end
    end
  endtask

  task automatic test_reset();
    bus.vga_x = 5; bus.vga_y = 5; bus.vga_colour = 2; bus.vga_plot = 1;
    bus.start = 1; bus.out_ready = 1; rst_n = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.plot_count !== 15'd0 || bus.oob_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_counters: plot=%0d oob=%0d want 0 0", bus.plot_count, bus.oob_count);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: valid=%b done=%b want 0 0", bus.out_valid, bus.done);
    end
    n_cmp++;
    if (bus.out_x !== 8'd0 || bus.out_y !== 7'd0 || bus.out_colour !== 3'd0) begin
      n_fail++; $display("FAIL reset_pixel: (%0d,%0d) c=%0d want (0,0) c=0", bus.out_x, bus.out_y, bus.out_colour);
    end
    bus.vga_plot = 0; bus.start = 0; bus.out_ready = 0; rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL idle_flags: valid=%b done=%b want 0 0", bus.out_valid, bus.done);
    end
  endtask

  task automatic test_fill_scan();
    for (int i = 0; i < N; i++) plot(i % W, i / W, 5);
    bus.vga_plot = 0;
    n_cmp++;
    if (bus.plot_count !== 15'(m_pc)) begin n_fail++; $display("FAIL fill_count: %0d want %0d", bus.plot_count, m_pc); end
    bus.out_ready = 1;
    start_scan(1);
    run_scan(0, N, 0);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL scan_done: done=%b valid=%b want 1 0", bus.done, bus.out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL done_hold: done=%b want 1", bus.done); end
    bus.start = 0;
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL done_release: done=%b valid=%b want 0 0", bus.done, bus.out_valid);
    end
    bus.out_ready = 0;
  endtask

  task automatic test_oob();
    plot(160, 0, 6);
    plot(0, 120, 6);
    plot(255, 127, 6);
    bus.vga_plot = 0;
    n_cmp++;
    if (bus.oob_count !== 8'(m_oc) || bus.plot_count !== 15'(m_pc)) begin
      n_fail++; $display("FAIL oob_counts: oob=%0d plot=%0d want %0d %0d", bus.oob_count, bus.plot_count, m_oc, m_pc);
    end
  endtask

  task automatic test_random_plots();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) plot(int'($urandom_range(0, 255)), 120 + int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      else plot(int'($urandom_range(0, W - 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) begin bus.vga_plot = 0; @(negedge clk); end
    end
    bus.vga_plot = 0;
    n_cmp++;
    if (bus.oob_count !== 8'(m_oc) || bus.plot_count !== 15'(m_pc)) begin
      n_fail++; $display("FAIL random_counts: oob=%0d plot=%0d want %0d %0d", bus.oob_count, bus.plot_count, m_oc, m_pc);
    end
  endtask

  task automatic test_backpressure_reset();
    logic [2:0] c5;
    bus.out_ready = 0;
    start_scan(0);
    run_scan(0, 5, 1);
    for (int t = 0; t < 4 && !bus.out_valid; t++) @(negedge clk);
    c5 = model[5];
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_x !== 8'd5 || bus.out_y !== 7'd0 || bus.out_colour !== c5) begin
      n_fail++; $display("FAIL bp_pixel: v=%b (%0d,%0d) c=%0d want v=1 (5,0) c=%0d", bus.out_valid, bus.out_x, bus.out_y, bus.out_colour, c5);
    end
    repeat (10) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_x !== 8'd5 || bus.out_y !== 7'd0 || bus.out_colour !== c5) begin
        n_fail++; $display("FAIL bp_hold: v=%b (%0d,%0d) c=%0d want v=1 (5,0) c=%0d", bus.out_valid, bus.out_x, bus.out_y, bus.out_colour, c5);
      end
    end
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_fetch: valid=%b want 0", bus.out_valid); end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_x !== 8'd6 || bus.out_y !== 7'd0) begin
      n_fail++; $display("FAIL bp_next: v=%b (%0d,%0d) want v=1 (6,0)", bus.out_valid, bus.out_x, bus.out_y);
    end
    run_scan(6, 3 * W + 40 - 6, 1);
    for (int t = 0; t < 4 && !bus.out_valid; t++) @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_x !== 8'd40 || bus.out_y !== 7'd3) begin
      n_fail++; $display("FAIL abort_pixel: v=%b (%0d,%0d) want v=1 (40,3)", bus.out_valid, bus.out_x, bus.out_y);
    end
    do_reset();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.plot_count !== 15'd0 || bus.oob_count !== 8'd0) begin
      n_fail++; $display("FAIL abort_state: v=%b done=%b plot=%0d oob=%0d want 0 0 0 0", bus.out_valid, bus.done, bus.plot_count, bus.oob_count);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_quiet: valid=%b want 0", bus.out_valid); end
    start_scan(0);
    run_scan(0, 3, 1);
    do_reset();
  endtask

  task automatic test_collision();
    plot(2, 0, 1);
    bus.vga_plot = 0;
    bus.out_ready = 1;
    start_scan(0);
    run_scan(0, 2, 0);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL coll_fetch: valid=%b want 0", bus.out_valid); end
    plot(2, 0, 7);
    bus.vga_plot = 0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_x !== 8'd2 || bus.out_colour !== 3'd1) begin
      n_fail++; $display("FAIL coll_old: v=%b x=%0d c=%0d want v=1 x=2 c=1", bus.out_valid, bus.out_x, bus.out_colour);
    end
    do_reset();
    bus.out_ready = 1;
    start_scan(0);
    run_scan(0, 3, 0);
    do_reset();
  endtask

  task automatic test_saturation();
    int pc0 = m_pc;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) plot(160 + int'($urandom_range(0, 95)), int'($urandom_range(0, 127)), 3);
      else plot(int'($urandom_range(0, 255)), 120 + int'($urandom_range(0, 7)), 3);
    end
    bus.vga_plot = 0;
    @(negedge clk);
    n_cmp++;
    if (bus.oob_count !== 8'(m_oc) || bus.plot_count !== 15'(pc0)) begin
      n_fail++; $display("FAIL saturate: oob=%0d plot=%0d want %0d %0d", bus.oob_count, bus.plot_count, m_oc, pc0);
    end
  endtask

  initial begin
    bus.vga_x = 0; bus.vga_y = 0; bus.vga_colour = 0; bus.vga_plot = 0;
    bus.start = 0; bus.out_ready = 0;
    @(negedge clk);
    test_reset();
    test_fill_scan();
    test_oob();
    test_random_plots();
    test_backpressure_reset();
    test_collision();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
